// File: rtl/mdu_iterative.sv
// Iterative MIPS multiply/divide unit that owns HI/LO: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MDU_EARLY_OUT_EN ends a multiply as soon as the remaining multiplier bits are zero.
module mdu_iterative #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [OP_WIDTH-1:0] OP_MULT  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_MULTU = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_DIV   = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_DIVU  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_MTHI  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_MTLO  = OP_WIDTH'(5);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [CW-1:0]  counter;
    logic           is_div;
    logic           neg_res;
    logic           neg_rem;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   opb;
    logic [W-1:0]   dividend;

    logic           op_valid;
    logic           op_div;
    logic           is_signed;
    logic           sign1;
    logic           sign2;
    logic [W-1:0]   mag1;
    logic [W-1:0]   mag2;

    // Signed ops work on magnitudes; the most-negative value maps to 2^(W-1) unsigned.
    always_comb begin
        op_valid  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        op_div    = (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        sign1     = is_signed & operand1[W-1];
        sign2     = is_signed & operand2[W-1];
        mag1      = sign1 ? -operand1 : operand1;
        mag2      = sign2 ? -operand2 : operand2;
    end

    logic [2*W-1:0] prod_next;
    logic [2*W-1:0] prod_signed;
    logic [W:0]     rem_shift;
    logic [W:0]     rem_diff;
    logic [W-1:0]   rem_next;
    logic [W-1:0]   quot_next;
    logic [W-1:0]   quot_signed;
    logic [W-1:0]   rem_signed;
    logic           last_iter;
    logic           finish;

    // acc holds the running product, or {remainder, dividend/quotient} while dividing.
    always_comb begin
        prod_next   = acc + (opb[0] ? mcand : '0);
        prod_signed = neg_res ? -prod_next : prod_next;
        rem_shift   = {acc[2*W-1:W], acc[W-1]};
        rem_diff    = rem_shift - {1'b0, opb};
        rem_next    = rem_diff[W] ? rem_shift[W-1:0] : rem_diff[W-1:0];
        quot_next   = {acc[W-2:0], ~rem_diff[W]};
        quot_signed = neg_res ? -quot_next : quot_next;
        rem_signed  = neg_rem ? -rem_next : rem_next;
        last_iter   = (counter == CW'(W-1));
`ifdef MDU_EARLY_OUT_EN
        finish      = last_iter || (!is_div && (opb[W-1:1] == '0));
`else
        finish      = last_iter;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            counter     <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            opb         <= '0;
            dividend    <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_valid) begin
                            state    <= BUSY;
                            busy     <= 1'b1;
                            counter  <= '0;
                            is_div   <= op_div;
                            neg_res  <= sign1 ^ sign2;
                            neg_rem  <= sign1;
                            mcand    <= {{W{1'b0}}, mag1};
                            opb      <= mag2;
                            acc      <= op_div ? {{W{1'b0}}, mag1} : '0;
                            dividend <= operand1;
                        end else if (op == OP_MTHI) begin
                            hi   <= operand1;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= operand1;
                            done <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    counter <= counter + 1'b1;
                    if (is_div) begin
                        acc <= {rem_next, quot_next};
                    end else begin
                        acc   <= prod_next;
                        mcand <= mcand << 1;
                        opb   <= opb >> 1;
                    end
                    // A zero divisor still runs full latency, then reports the MIPS-style fallback.
                    if (finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (is_div) begin
                            if (opb == '0) begin
                                hi          <= dividend;
                                lo          <= '1;
                                div_by_zero <= 1'b1;
                            end else begin
                                hi <= rem_signed;
                                lo <= quot_signed;
                            end
                        end else begin
                            {hi, lo} <= prod_signed;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// Randomized scoreboard bench for mdu_iterative; a plain-arithmetic model predicts hi/lo, div_by_zero and latency.
module tb_mdu_iterative;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mdu_iterative #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand1(operand1), .operand2(operand2),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           cycle = 0;
    int           start_cycle = 0;
    logic         exp_busy = 1'b0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural results from plain 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
        longint         sa;
        longint         sbv;
        logic [2*W-1:0] p;
        logic [W-1:0]   mb;
        e.dbz = 1'b0;
        e.lat = W;
        mb    = b;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        case (o)
            3'd0, 3'd1: begin
                if (o == 3'd0) begin
                    p  = 64'(sa * sbv);
                    mb = b[W-1] ? -b : b;
                end else begin
                    p = {32'b0, a} * {32'b0, b};
                end
                {model_hi, model_lo} = p;
`ifdef MDU_EARLY_OUT_EN
                e.lat = 1;
                for (int i = 0; i < W; i++) if (mb[i]) e.lat = i + 1;
`endif
            end
            3'd2, 3'd3: begin
                if (b == '0) begin
                    model_hi = a;
                    model_lo = '1;
                    e.dbz    = 1'b1;
                end else if (o == 3'd2) begin
                    model_lo = W'(sa / sbv);
                    model_hi = W'(sa % sbv);
                end else begin
                    model_lo = a / b;
                    model_hi = a % b;
                end
            end
            3'd4: begin model_hi = a; e.lat = 0; end
            3'd5: begin model_lo = a; e.lat = 0; end
            default: e.lat = 0;
        endcase
        e.hi = model_hi;
        e.lo = model_lo;
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while (busy && guard < 4*W) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4*W) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: busy stuck got %b expected 0", busy);
        end
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        model(o, a, b, e);
        @(posedge clk);
        #1;
        start       = 1'b0;
        start_cycle = cycle;
        if (o <= 3'd3) exp_busy = 1'b1;
        if (o <= 3'd5) sb_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every done pulse and checks busy each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_output("hi", hi, e.hi);
                    check_output("lo", lo, e.lo);
                    check_output("div_by_zero", div_by_zero, e.dbz);
                    check_output("latency", cycle - start_cycle, e.lat);
                    exp_busy = 1'b0;
                end
            end else if (div_by_zero) begin
                checks++;
                errors++;
                $display("[TB] FAIL dbz_without_done: got 1 expected 0");
            end
            if (exp_busy && (cycle - start_cycle > W + 4)) begin
                checks++;
                errors++;
                $display("[TB] FAIL timeout: got no done after %0d cycles expected %0d", cycle - start_cycle, W);
                exp_busy = 1'b0;
                sb_q.delete();
            end
            check_output("busy", busy, exp_busy);
        end
    end

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int guard;
        repeat (2) @(negedge clk);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_hi", hi, 0);
        check_output("reset_lo", lo, 0);
        rst_n = 1'b1;

        apply_stimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply_stimulus(3'd0, 32'hFFFF_FFFD, 32'd7);
        apply_stimulus(3'd0, 32'h8000_0000, 32'h8000_0000);
        apply_stimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        apply_stimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        apply_stimulus(3'd3, 32'h0000_0064, 32'd0);
        apply_stimulus(3'd2, 32'hFFFF_FFF9, 32'd0);
        apply_stimulus(3'd4, 32'h0000_1234, 32'd0);
        apply_stimulus(3'd5, 32'h0000_5678, 32'd0);
        apply_stimulus(3'd1, 32'd5, 32'd3);

        // A start while busy must be ignored.
        apply_stimulus(3'd1, 32'h0001_0001, 32'h0000_FFFF);
        while (cycle < start_cycle + 5) @(negedge clk);
        start    = 1'b1;
        op       = 3'd3;
        operand1 = 32'd99;
        operand2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reserved op: no done, no busy, hi/lo untouched.
        apply_stimulus(3'd6, 32'hDEAD_BEEF, 32'd1);
        check_output("reserved_done", done, 0);
        check_output("reserved_busy", busy, 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of an operation aborts it.
        apply_stimulus(3'd1, 32'd12345, 32'd6789);
        while (cycle < start_cycle + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_hi", hi, 0);
        check_output("abort_lo", lo, 0);
        sb_q.delete();
        exp_busy = 1'b0;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(3'd4, 32'h0000_1234, 32'd0);

        for (int n = 0; n < 40; n++) begin
            apply_stimulus(3'($urandom_range(0, 5)), pick_operand(), pick_operand());
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 4*W) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
